// File: rtl/wm8731_cfg_seq.sv
// wm8731_cfg_seq: writes the 11-entry WM8731 setup table over SCLK/SDAT.
// Define WM8731_CFG_RETRY_EN to retry a NACKed entry up to 3 times.
module wm8731_cfg_seq #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned I2C_HZ     = 100000,
    parameter logic [6:0]  DEV_ADDR   = 7'h1A,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic       clk_clk,
    input  logic       resetxd_reset_n,
    input  logic       start,
    output logic       i2c_sclk,
    output logic       sdat_oe,
    input  logic       sdat_in,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [3:0] reg_index
);
    localparam int unsigned QDIV = CLK_HZ / (4 * I2C_HZ);
    localparam int unsigned QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_ACK,
        S_STOP,
        S_GAP,
        S_FINISH
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [QW-1:0] qcnt;
    logic [1:0]    q;
    logic [2:0]    bitn;
    logic [1:0]    byten;
    logic          fail;
    logic          auto_pend;
    logic          qend;
    logic          samp;
    logic          bend;
    logic          launch;
    logic          give_up;
    logic          last_entry;
    logic [15:0]   entry;
    logic [7:0]    tx_byte;
    logic          tx_bit;

    assign qend       = (qcnt == QLAST);
    assign samp       = qend && (q == 2'd2);
    assign bend       = qend && (q == 2'd3);
    assign launch     = start || auto_pend;
    assign last_entry = (reg_index == 4'd10);

`ifdef WM8731_CFG_RETRY_EN
    logic [1:0] rty;

    always_ff @(posedge clk_clk) begin
        if (!resetxd_reset_n) begin
            rty <= 2'd0;
        end else if (state == S_IDLE && launch) begin
            rty <= 2'd0;
        end else if (state == S_GAP && bend) begin
            rty <= fail ? rty + 2'd1 : 2'd0;
        end
    end

    assign give_up = fail && (rty == 2'd3);
`else
    assign give_up = fail;
`endif

    // {reg[6:0], data[8:0]}
    always_comb begin
        entry = 16'h0000;
        case (reg_index)
            4'd0:    entry = {7'd15, 9'h000};
            4'd1:    entry = {7'd0,  9'h017};
            4'd2:    entry = {7'd1,  9'h017};
            4'd3:    entry = {7'd2,  9'h079};
            4'd4:    entry = {7'd3,  9'h079};
            4'd5:    entry = {7'd4,  9'h012};
            4'd6:    entry = {7'd5,  9'h000};
            4'd7:    entry = {7'd6,  9'h000};
            4'd8:    entry = {7'd7,  9'h042};
            4'd9:    entry = {7'd8,  9'h000};
            4'd10:   entry = {7'd9,  9'h001};
            default: entry = 16'h0000;
        endcase
    end

    always_comb begin
        tx_byte = entry[7:0];
        case (byten)
            2'd0:    tx_byte = {DEV_ADDR, 1'b0};
            2'd1:    tx_byte = entry[15:8];
            default: tx_byte = entry[7:0];
        endcase
    end

    assign tx_bit = tx_byte[3'd7 - bitn];

    always_ff @(posedge clk_clk) begin
        if (!resetxd_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (launch) state_nx = S_START;
            S_START:  if (bend) state_nx = S_SHIFT;
            S_SHIFT:  if (bend && bitn == 3'd7) state_nx = S_ACK;
            S_ACK: begin
                if (bend) begin
                    state_nx = (fail || byten == 2'd2) ? S_STOP : S_SHIFT;
                end
            end
            S_STOP:   if (bend) state_nx = give_up ? S_IDLE : S_GAP;
            S_GAP: begin
                if (bend) begin
                    state_nx = (!fail && last_entry) ? S_FINISH : S_START;
                end
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        i2c_sclk = 1'b1;
        sdat_oe  = 1'b0;
        unique case (state)
            S_START: begin
                i2c_sclk = (q != 2'd3);
                sdat_oe  = q[1];
            end
            S_SHIFT: begin
                i2c_sclk = q[1];
                sdat_oe  = !tx_bit;
            end
            S_ACK: i2c_sclk = q[1];
            S_STOP: begin
                i2c_sclk = (q != 2'd0);
                sdat_oe  = (q != 2'd3);
            end
            default: begin
                i2c_sclk = 1'b1;
                sdat_oe  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!resetxd_reset_n) begin
            qcnt      <= '0;
            q         <= 2'd0;
            bitn      <= 3'd0;
            byten     <= 2'd0;
            fail      <= 1'b0;
            auto_pend <= AUTO_START;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_err   <= 1'b0;
            reg_index <= 4'd0;
        end else begin
            if (state == S_IDLE) begin
                qcnt <= '0;
                q    <= 2'd0;
                if (launch) begin
                    auto_pend <= 1'b0;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    ack_err   <= 1'b0;
                    reg_index <= 4'd0;
                end
            end else if (state != S_FINISH) begin
                qcnt <= qend ? '0 : qcnt + QW'(1);
                if (qend) q <= q + 2'd1;
            end
            if (state == S_START) begin
                bitn  <= 3'd0;
                byten <= 2'd0;
                fail  <= 1'b0;
            end
            if (state == S_SHIFT && bend) bitn <= bitn + 3'd1;
            if (state == S_ACK && samp) fail <= sdat_in;
            if (state == S_ACK && bend) byten <= byten + 2'd1;
            if (state == S_STOP && bend && give_up) begin
                ack_err <= 1'b1;
                busy    <= 1'b0;
            end
            // a failed entry keeps its index so it is retried
            if (state == S_GAP && bend && !fail) begin
                if (last_entry) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end else begin
                    reg_index <= reg_index + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// tb_wm8731_cfg_seq: bus-level slave model plus a transaction-level reference
// for the byte stream, final status and completion cycle.
`timescale 1ns/1ps
module tb_wm8731_cfg_seq;
    localparam int LIMIT = 4000;
`ifdef WM8731_CFG_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       i2c_sclk;
    logic       sdat_oe;
    logic       sdat_in;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [3:0] reg_index;
    logic       drv = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    int nack_reg  = -1;
    int nack_byte = 0;
    int nack_lim  = 0;

    int   n_start = 0;
    int   n_stop  = 0;
    int   got_q[$];
    int   exp_q[$];
    int   nack_used;
    int   bcnt;
    int   bidx;
    int   cur_reg;
    logic prev_scl;
    logic prev_sda;
    logic [7:0] sh;
    bit   acking;
    bit   ack_hi;

    int tbl_reg [11] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    int tbl_dat [11] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012,
                         'h000, 'h000, 'h042, 'h000, 'h001};

    assign sdat_in = ~(sdat_oe | drv);

    always #5 clk = ~clk;

    wm8731_cfg_seq #(
        .CLK_HZ    (400),
        .I2C_HZ    (100),
        .DEV_ADDR  (7'h1A),
        .AUTO_START(1'b1)
    ) dut (
        .clk_clk        (clk),
        .resetxd_reset_n(rst_n),
        .start          (start),
        .i2c_sclk       (i2c_sclk),
        .sdat_oe        (sdat_oe),
        .sdat_in        (sdat_in),
        .busy           (busy),
        .done           (done),
        .ack_err        (ack_err),
        .reg_index      (reg_index)
    );

    // slave: decodes START/STOP/bytes, ACKs unless the NACK policy matches
    always @(negedge clk) begin
        logic scl;
        logic sd;
        bit   nk;
        if (!rst_n) begin
            prev_scl  = 1'b1;
            prev_sda  = 1'b1;
            bcnt      = 0;
            bidx      = 0;
            cur_reg   = -1;
            acking    = 0;
            ack_hi    = 0;
            drv       = 1'b0;
            nack_used = 0;
        end else begin
            scl = i2c_sclk;
            sd  = sdat_in;
            if (prev_scl && scl && prev_sda && !sd) begin
                n_start++;
                bcnt   = 0;
                bidx   = 0;
                acking = 0;
                ack_hi = 0;
                drv    = 1'b0;
            end
            if (prev_scl && scl && !prev_sda && sd) begin
                n_stop++;
                bcnt = 0;
                bidx = 0;
            end
            if (!prev_scl && scl) begin
                if (acking) begin
                    ack_hi = 1;
                end else begin
                    sh = {sh[6:0], sd};
                    bcnt++;
                end
            end
            if (!scl && acking && ack_hi) begin
                drv    = 1'b0;
                acking = 0;
                ack_hi = 0;
            end else if (!scl && !acking && bcnt == 8) begin
                got_q.push_back(int'(sh));
                if (bidx == 1) cur_reg = int'(sh[7:1]);
                nk = (nack_reg >= 0) && (bidx == nack_byte) &&
                     (cur_reg == nack_reg) && (nack_used < nack_lim);
                if (nk) nack_used++;
                drv    = !nk;
                acking = 1;
                ack_hi = 0;
                bcnt   = 0;
                bidx++;
            end
            prev_scl = scl;
            prev_sda = sd;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int tbl_byte(int e, int b);
        if (b == 0) return 'h34;
        if (b == 1) return tbl_reg[e] * 2 + tbl_dat[e] / 256;
        return tbl_dat[e] % 256;
    endfunction

    // transaction-level reference: bytes sent, bit times, final status
    task automatic model(input int nreg, input int nb, input int nlim,
                         output int n_end, output int idx,
                         output bit ok, output int ntx);
        int e = 0;
        int bits = 0;
        int used = 0;
        int rty = 0;
        int failb;
        bit err = 0;
        ntx = 0;
        exp_q.delete();
        while (e < 11 && !err) begin
            ntx++;
            failb = -1;
            for (int b = 0; b < 3; b++) begin
                exp_q.push_back(tbl_byte(e, b));
                if (nreg == tbl_reg[e] && b == nb && used < nlim) begin
                    used++;
                    failb = b;
                    break;
                end
            end
            if (failb < 0) begin
                bits += 30;
                rty = 0;
                e++;
            end else if (RETRY && rty < 3) begin
                bits += 3 + 9 * (failb + 1);
                rty++;
            end else begin
                bits += 2 + 9 * (failb + 1);
                err = 1;
            end
        end
        n_end = 1 + 4 * bits;
        idx   = err ? e : 10;
        ok    = !err;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        tick();
        tick();
        check("rst_sclk", i2c_sclk, 1);
        check("rst_oe", sdat_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", ack_err, 0);
        check("rst_idx", reg_index, 0);
    endtask

    task automatic expect_run(input int nreg, input int nb, input int nlim,
                              input int pulse_n, input bit by_start,
                              output bit ok);
        int n_end;
        int idx;
        int ntx;
        int n;
        int got_n;
        int s0;
        int p0;
        int g0;
        nack_reg  = nreg;
        nack_byte = nb;
        nack_lim  = nlim;
        model(nreg, nb, nlim, n_end, idx, ok, ntx);
        s0 = n_start;
        p0 = n_stop;
        g0 = got_q.size();
        if (by_start) start = 1'b1;
        else rst_n = 1'b1;
        n = 0;
        got_n = -1;
        while (n < LIMIT && got_n < 0) begin
            tick();
            n++;
            start = 1'b0;
            if (n == 1) begin
                check("busy_rise", busy, 1);
                check("idx_clr", reg_index, 0);
                check("err_clr", ack_err, 0);
            end
            if (n == n_end - 1) check("busy_hold", busy, 1);
            if (n == pulse_n) begin
                check("idx_pulse", reg_index, 4);
                start = 1'b1;
            end
            if (!busy && (done || ack_err)) got_n = n;
        end
        check("end_cycle", got_n, n_end);
        check("done", done, ok);
        check("ack_err", ack_err, !ok);
        check("reg_index", reg_index, idx);
        check("n_start", n_start - s0, ntx);
        check("n_stop", n_stop - p0, ntx);
        check("n_bytes", got_q.size() - g0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (g0 + i < got_q.size()) begin
                check($sformatf("byte%0d", i), got_q[g0 + i], exp_q[i]);
            end
        end
    endtask

    task automatic nack_case(input int nreg, input int nb, input int nlim);
        bit ok;
        do_reset();
        expect_run(nreg, nb, nlim, -1, 1'b0, ok);
        if (!ok) expect_run(-1, 0, 0, -1, 1'b1, ok);
    endtask

    initial begin
        bit ok;
        int k;
        int n;
        do_reset();
        expect_run(-1, 0, 0, -1, 1'b0, ok);

        do_reset();
        n = 1 + 4 * (121 + $urandom_range(0, 26)) + $urandom_range(0, 3);
        expect_run(-1, 0, 0, n, 1'b0, ok);

        do_reset();
        k = $urandom_range(0, 10);
        n = 1 + 4 * (30 * k + 1 + $urandom_range(0, 7)) + $urandom_range(0, 3);
        rst_n = 1'b1;
        repeat (n) tick();
        check("pre_rst_busy", busy, 1);
        check("pre_rst_idx", reg_index, k);
        rst_n = 1'b0;
        tick();
        check("mid_rst_sclk", i2c_sclk, 1);
        check("mid_rst_oe", sdat_oe, 0);
        check("mid_rst_busy", busy, 0);
        expect_run(-1, 0, 0, -1, 1'b0, ok);

        nack_case(5, 1, RETRY ? 4 : 1);
        nack_case(3, $urandom_range(1, 2), 2);
        nack_case(3, $urandom_range(1, 2), 4);
        repeat (3) begin
            nack_case(tbl_reg[$urandom_range(0, 10)], $urandom_range(1, 2),
                      $urandom_range(1, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wm8731_cfg_seq.md
Name: wm8731_cfg_seq

Overview:
- Power-up configuration sequencer for the WM8731 audio codec on the SoC's two-wire audio_config bus (SCLK/SDAT).
- Walks a fixed 11-entry register table and issues one 3-byte I2C write per entry: device address, {reg[6:0], data[8]}, data[7:0].
- Reports busy/done/ack-error status so the audio datapath is held off until the codec is configured (master mode, I2S, DAC selected, 48 kHz).

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- I2C_HZ, 100000, SCLK frequency. QDIV = CLK_HZ/(4*I2C_HZ) cycles per quarter-bit; QDIV must be >= 1.
- DEV_ADDR, 7'h1A, codec 7-bit address (write byte 0x34).
- AUTO_START, 1, start the sequence on the first cycle after reset release.

Ports:
- clk_clk  in  1  system clock; all logic on rising edge.
- resetxd_reset_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; begins the sequence; ignored while busy.
- i2c_sclk  out  1  SCLK, push-pull.
- sdat_oe  out  1  1 = pull SDAT low; 0 = release (pull-up gives high).
- sdat_in  in  1  sampled SDAT line.
- busy  out  1  high from start until finish or abort.
- done  out  1  sticky; set after all 11 writes are ACKed; cleared on start.
- ack_err  out  1  sticky; set on abort; cleared on start.
- reg_index  out  4  table entry currently being written (0..10).

Behaviour:
- Reset values: i2c_sclk=1, sdat_oe=0, busy=0, done=0, ack_err=0, reg_index=0. FSM=IDLE, quarter counter=0.
- Reset mid-transfer aborts immediately to these values. No STOP is generated.
- Table, as {reg, data9}, in order: {15,0x000}, {0,0x017}, {1,0x017}, {2,0x079}, {3,0x079}, {4,0x012}, {5,0x000}, {6,0x000}, {7,0x042}, {8,0x000}, {9,0x001}.
- Timing unit: one bit = 4 quarters of QDIV cycles each (phases q0..q3).
- Data bit: SCLK low in q0 and q1, high in q2 and q3. SDAT changes only at the start of q0. The slave bit is sampled on the last cycle of q2.
- States:
  - IDLE: waits for start (or the post-reset trigger if AUTO_START).
  - START, one bit time: SDAT released with SCLK high in q0/q1; SDAT driven low in q2; SCLK low in q3.
  - SHIFT: 8 bits, MSB first; bit=0 → sdat_oe=1, bit=1 → sdat_oe=0.
  - ACK: sdat_oe=0 for one bit; sdat_in sampled.
  - STOP, one bit time: SDAT low in q0/q1, SCLK high from q1, SDAT released in q3.
  - GAP: one bit time idle, SCLK=1, SDAT released.
  - FINISH.
- Per transaction: START, then 3 × (SHIFT + ACK), then STOP, then GAP = 30 bit times = 120*QDIV cycles.
- ACK sampled 0 → next byte. After the 3rd ACK → STOP → GAP, then:
  - reg_index < 10: reg_index+1, back to START.
  - reg_index = 10: FINISH.
- ACK sampled 1 (NACK) → STOP → ack_err=1, busy=0, done=0, return to IDLE. reg_index holds the failing entry.
- FINISH: done=1, busy=0 in the same cycle; then IDLE.
- start while busy: ignored. start in IDLE: reg_index=0, done and ack_err cleared, busy=1 on the next cycle.
- Total for a clean run: 11 × 120 × QDIV cycles, +1 cycle for the start latch.

Optional Feature:
- Macro: WM8731_CFG_RETRY_EN.
- Defined: a NACK does not abort immediately. After STOP+GAP the same entry is retried, up to 3 retries (4 attempts). A 2-bit retry counter clears on each successful entry. ack_err is set only after the 4th consecutive NACK on one entry.
- Undefined: the first NACK aborts as described in Behaviour. No retry counter is present.

Test Plan:
- CLK_HZ=400, I2C_HZ=100 (QDIV=1), AUTO_START=1, slave model ACKs everything:
  - decoded bytes are 0x34,0x1E,0x00 / 0x34,0x00,0x17 / … / 0x34,0x0E,0x42 / 0x34,0x10,0x00 / 0x34,0x12,0x01.
  - done=1 and busy=0 exactly 1 + 11×120 cycles after reset release.
- START/STOP legality: a monitor checks SDAT never changes while SCLK=1 except START (1→0) and STOP (0→1). Exactly 11 STARTs and 11 STOPs are seen.
- Slave NACKs the 2nd byte of entry 5 (no retry build) → STOP issued, ack_err=1, done=0, busy=0, reg_index=5. A following start pulse clears ack_err and restarts at reg_index=0.
- WM8731_CFG_RETRY_EN build:
  - entry 3 NACKed twice then ACKed → 13 transactions total, done=1, ack_err=0.
  - NACKed 4 times → ack_err=1, reg_index=3.
- start pulsed at reg_index=4 mid-byte → ignored; sequence unchanged.
- resetxd_reset_n low mid-SHIFT for 1 cycle → next cycle sclk=1, sdat_oe=0, busy=0. With AUTO_START=1 the sequence restarts from entry 0.
